// File: rtl/load_access_ctrl.sv
// Load access controller: word-aligned request/ack reads with byte/half/word extraction.
// Define MISALIGN_SPLIT_EN to service misaligned loads as two word reads; otherwise they error.
module load_access_ctrl #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_func3,
  output logic        req_ready,
  output logic        dm_req,
  output logic [31:0] dm_addr,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        stall
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t          state, state_nxt;
  logic [31:0]     addr_q;
  logic [2:0]      func3_q;
  logic [CW-1:0]   wait_cnt;
  logic            clr_wait;
  logic            load_rsp;
  logic [31:0]     rsp_data_nxt;
  logic            rsp_err_nxt;
  logic            timeout;

  function automatic logic is_legal(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: is_legal = 1'b1;
      default:                                is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b001, 3'b101: is_misaligned = off[0];
      3'b010:         is_misaligned = (off != 2'b00);
      default:        is_misaligned = 1'b0;
    endcase
  endfunction

  // Shift the two-word window down to the addressed byte, then size and extend.
  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [63:0] pair);
    logic [31:0] raw;
    raw = 32'(pair >> {off, 3'b000});
    case (f3)
      3'b000:  extract = {{24{raw[7]}}, raw[7:0]};
      3'b001:  extract = {{16{raw[15]}}, raw[15:0]};
      3'b100:  extract = {24'h0, raw[7:0]};
      3'b101:  extract = {16'h0, raw[15:0]};
      default: extract = raw;
    endcase
  endfunction

  assign timeout   = !dm_ack && (wait_cnt == CW'(MAX_WAIT - 1));
  assign rsp_valid = (state == RESP);
  assign stall     = (state != IDLE);

`ifdef MISALIGN_SPLIT_EN
  logic [31:0] word0_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      word0_q <= '0;
    else if (state == ACC0 && dm_ack)
      word0_q <= dm_rdata;
  end
`endif

  always_comb begin
    state_nxt    = state;
    req_ready    = 1'b0;
    dm_req       = 1'b0;
    dm_addr      = '0;
    clr_wait     = 1'b0;
    load_rsp     = 1'b0;
    rsp_data_nxt = '0;
    rsp_err_nxt  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (!is_legal(req_func3)) begin
            state_nxt   = RESP;
            load_rsp    = 1'b1;
            rsp_err_nxt = 1'b1;
          end else if (is_misaligned(req_func3, req_addr[1:0])) begin
`ifdef MISALIGN_SPLIT_EN
            state_nxt = ACC0;
            clr_wait  = 1'b1;
`else
            state_nxt   = RESP;
            load_rsp    = 1'b1;
            rsp_err_nxt = 1'b1;
`endif
          end else begin
            state_nxt = ACC0;
            clr_wait  = 1'b1;
          end
        end
      end
      ACC0: begin
        dm_req  = 1'b1;
        dm_addr = {addr_q[31:2], 2'b00};
        if (dm_ack) begin
`ifdef MISALIGN_SPLIT_EN
          if (is_misaligned(func3_q, addr_q[1:0])) begin
            state_nxt = ACC1;
            clr_wait  = 1'b1;
          end else begin
            state_nxt    = RESP;
            load_rsp     = 1'b1;
            rsp_data_nxt = extract(func3_q, addr_q[1:0], {32'h0, dm_rdata});
          end
`else
          state_nxt    = RESP;
          load_rsp     = 1'b1;
          rsp_data_nxt = extract(func3_q, addr_q[1:0], {32'h0, dm_rdata});
`endif
        end else if (timeout) begin
          state_nxt   = RESP;
          load_rsp    = 1'b1;
          rsp_err_nxt = 1'b1;
        end
      end
`ifdef MISALIGN_SPLIT_EN
      ACC1: begin
        dm_req  = 1'b1;
        dm_addr = {addr_q[31:2], 2'b00} + 32'd4;
        if (dm_ack) begin
          state_nxt    = RESP;
          load_rsp     = 1'b1;
          rsp_data_nxt = extract(func3_q, addr_q[1:0], {dm_rdata, word0_q});
        end else if (timeout) begin
          state_nxt   = RESP;
          load_rsp    = 1'b1;
          rsp_err_nxt = 1'b1;
        end
      end
`endif
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      func3_q  <= '0;
      wait_cnt <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid) begin
        addr_q  <= req_addr;
        func3_q <= req_func3;
      end
      if (clr_wait)
        wait_cnt <= '0;
      else if (state == ACC0 || state == ACC1)
        wait_cnt <= wait_cnt + CW'(1);
      if (load_rsp) begin
        rsp_data <= rsp_data_nxt;
        rsp_err  <= rsp_err_nxt;
      end
    end
  end

endmodule

// File: tb/tb_load_access_ctrl.sv
// Directed self-checking bench for load_access_ctrl with a small ack-delay memory model.
// Split-access expectations follow MISALIGN_SPLIT_EN when it is defined for the build.
module tb_load_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [2:0]  req_func3;
  logic        req_ready;
  logic        dm_req;
  logic [31:0] dm_addr;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        stall;

  int passCount  = 0;
  int checkCount = 0;

  int          r_lat;
  logic [31:0] r_data;
  logic        r_err;
  logic [31:0] r_first_addr;
  logic        r_saw_req;
  logic        r_stall_ok;
  logic        r_req_at_rsp;

  load_access_ctrl #(.MAX_WAIT(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_func3 (req_func3),
    .req_ready (req_ready),
    .dm_req    (dm_req),
    .dm_addr   (dm_addr),
    .dm_ack    (dm_ack),
    .dm_rdata  (dm_rdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .stall     (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected)
      passCount++;
    else
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
  endtask

  // Issue one load and play memory: ack each access after ack_delay wait cycles (-1 = never).
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] addr,
                               input int ack_delay, input logic [31:0] w0,
                               input logic [31:0] w1);
    logic [31:0] last_addr;
    int k;
    @(negedge clk);
    req_valid    = 1'b1;
    req_addr     = addr;
    req_func3    = f3;
    r_lat        = -1;
    r_data       = 32'hDEAD_BEEF;
    r_err        = 1'bx;
    r_saw_req    = 1'b0;
    r_stall_ok   = 1'b1;
    r_req_at_rsp = 1'bx;
    r_first_addr = 32'hFFFF_FFFF;
    last_addr    = 32'hFFFF_FFFF;
    k            = 0;
    for (int n = 1; n <= 60 && r_lat < 0; n++) begin
      @(negedge clk);
      req_valid = 1'b0;
      dm_ack    = 1'b0;
      if (!stall) r_stall_ok = 1'b0;
      if (rsp_valid) begin
        r_lat        = n;
        r_data       = rsp_data;
        r_err        = rsp_err;
        r_req_at_rsp = dm_req;
      end else if (dm_req) begin
        if (!r_saw_req) r_first_addr = dm_addr;
        r_saw_req = 1'b1;
        if (dm_addr != last_addr) k = 0;
        last_addr = dm_addr;
        if (k == ack_delay) begin
          dm_ack   = 1'b1;
          dm_rdata = (dm_addr == r_first_addr) ? w0 : w1;
        end
        k++;
      end
    end
    dm_ack = 1'b0;
  endtask

  initial begin
    int pulses;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_func3 = '0;
    dm_ack    = 1'b0;
    dm_rdata  = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_dm_req",    32'(dm_req),    32'd0);
    checkOutput("rst_dm_addr",   dm_addr,        32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_data",  rsp_data,       32'd0);
    checkOutput("rst_rsp_err",   32'(rsp_err),   32'd0);
    checkOutput("rst_stall",     32'(stall),     32'd0);
    rst_n = 1'b1;

    // lb from byte 3, zero-wait ack
    applyStimulus(3'b000, 32'h0000_0103, 0, 32'h80FF_1234, 32'h0);
    checkOutput("lb_dm_addr", r_first_addr, 32'h0000_0100);
    checkOutput("lb_latency", 32'(r_lat),   32'd2);
    checkOutput("lb_data",    r_data,       32'hFFFF_FF80);
    checkOutput("lb_err",     32'(r_err),   32'd0);
    checkOutput("lb_stall",   32'(r_stall_ok), 32'd1);

    // lhu with three wait cycles
    applyStimulus(3'b101, 32'h0000_0202, 3, 32'h9ABC_0000, 32'h0);
    checkOutput("lhu_latency", 32'(r_lat), 32'd5);
    checkOutput("lhu_data",    r_data,     32'h0000_9ABC);
    checkOutput("lhu_err",     32'(r_err), 32'd0);
    checkOutput("lhu_stall",   32'(r_stall_ok), 32'd1);
    @(negedge clk);
    checkOutput("lhu_idle_ready", 32'(req_ready), 32'd1);
    checkOutput("lhu_idle_stall", 32'(stall),     32'd0);

    // misaligned lw across a word boundary
    applyStimulus(3'b010, 32'h0000_0301, 0, 32'h4433_2211, 32'h8877_6655);
`ifdef MISALIGN_SPLIT_EN
    checkOutput("lw_split_latency", 32'(r_lat), 32'd3);
    checkOutput("lw_split_data",    r_data,     32'h5544_3322);
    checkOutput("lw_split_err",     32'(r_err), 32'd0);
`else
    checkOutput("lw_mis_latency", 32'(r_lat),     32'd1);
    checkOutput("lw_mis_data",    r_data,         32'd0);
    checkOutput("lw_mis_err",     32'(r_err),     32'd1);
    checkOutput("lw_mis_no_req",  32'(r_saw_req), 32'd0);
`endif

    // ack withheld: times out after MAX_WAIT wait cycles
    applyStimulus(3'b010, 32'h0000_0400, -1, 32'h1111_1111, 32'h0);
    checkOutput("to_latency",   32'(r_lat),        32'd17);
    checkOutput("to_dm_req",    32'(r_req_at_rsp), 32'd0);
    checkOutput("to_err",       32'(r_err),        32'd1);
    checkOutput("to_data",      r_data,            32'd0);
    @(negedge clk);
    checkOutput("to_idle_ready", 32'(req_ready), 32'd1);

    // illegal func3
    applyStimulus(3'b011, 32'h0000_0500, 0, 32'h1234_5678, 32'h0);
    checkOutput("ill_latency", 32'(r_lat),     32'd1);
    checkOutput("ill_err",     32'(r_err),     32'd1);
    checkOutput("ill_data",    r_data,         32'd0);
    checkOutput("ill_no_req",  32'(r_saw_req), 32'd0);

    // back-to-back: lb 0x0 then lh 0x2 with req_valid held high
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h0;
    req_func3 = 3'b000;
    dm_rdata  = 32'h8001_00F0;
    pulses    = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      dm_ack = dm_req;
      if (i == 1) begin
        req_addr  = 32'h2;
        req_func3 = 3'b001;
      end
      if (i == 4) req_valid = 1'b0;
      if (rsp_valid) begin
        pulses++;
        if (pulses == 1) begin
          checkOutput("b2b_first_cycle", 32'(i), 32'd2);
          checkOutput("b2b_first_data",  rsp_data, 32'hFFFF_FFF0);
          checkOutput("b2b_first_ready", 32'(req_ready), 32'd0);
        end else if (pulses == 2) begin
          checkOutput("b2b_second_cycle", 32'(i), 32'd5);
          checkOutput("b2b_second_data",  rsp_data, 32'hFFFF_8001);
          checkOutput("b2b_second_err",   32'(rsp_err), 32'd0);
        end
      end
    end
    dm_ack = 1'b0;
    checkOutput("b2b_pulses", 32'(pulses), 32'd2);

    // async reset during ACC0 drops the access; a late ack is ignored
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h0000_0600;
    req_func3 = 3'b010;
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("acc0_dm_req",  32'(dm_req), 32'd1);
    checkOutput("acc0_dm_addr", dm_addr,     32'h0000_0600);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_dm_req",   32'(dm_req),    32'd0);
    checkOutput("arst_dm_addr",  dm_addr,        32'd0);
    checkOutput("arst_rsp_data", rsp_data,       32'd0);
    checkOutput("arst_rsp_err",  32'(rsp_err),   32'd0);
    checkOutput("arst_stall",    32'(stall),     32'd0);
    checkOutput("arst_ready",    32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n    = 1'b1;
    dm_ack   = 1'b1;
    dm_rdata = 32'hCAFE_F00D;
    pulses   = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid || stall || dm_req) pulses++;
    end
    dm_ack = 1'b0;
    checkOutput("late_ack_ignored", 32'(pulses), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
